branch_hazard_ctrl: RTL and testbench
=====================================

Name: branch_hazard_ctrl

Overview:
Sequences the ID-stage branch comparator in the 5-stage RV32I pipeline. It detects operand hazards for a conditional branch sitting in IF/ID and stalls for the required cycles. It then selects the forwarding sources for the comparator operands and, on a taken branch, issues the PC redirect and IF/ID flush. It also keeps branch and stall statistics counters.

Parameters:
XLEN, 32, datapath and PC width
CNT_W, 32, width of statistics counters

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
if_id_inst_code  in  32  instruction in IF/ID
ext_stall  in  1  global pipeline freeze (memory wait); FSM and counters hold
id_ex_rd  in  5  destination register in ID/EX
id_ex_regwrite  in  1  ID/EX writes rd
id_ex_memread  in  1  ID/EX is a load
ex_mem_rd  in  5  destination register in EX/MEM
ex_mem_regwrite  in  1  EX/MEM writes rd
ex_mem_memread  in  1  EX/MEM is a load
mem_wb_rd  in  5  destination register in MEM/WB
mem_wb_regwrite  in  1  MEM/WB writes rd
beq_select  in  1  comparator result (branch taken)
branch_target  in  XLEN  PC + B-immediate computed in ID
stall  out  1  hold PC and IF/ID
id_ex_bubble  out  1  insert NOP into ID/EX
fwd_a_sel  out  2  rs1 operand source: 0 regfile, 1 EX/MEM ALU result, 2 MEM/WB writeback data
fwd_b_sel  out  2  rs2 operand source, same encoding
pc_redirect  out  1  load PC from redirect_pc
redirect_pc  out  XLEN  equals branch_target
if_id_flush  out  1  squash instruction fetched behind the branch
branch_count  out  CNT_W  resolved branches
taken_count  out  CNT_W  taken branches
stall_cycles  out  CNT_W  cycles stalled by this block

Behaviour:
- Branch detect: opcode 7'b1100011 with funct3 in {0,1,4,5,6,7}. Other funct3 values are treated as a non-branch. rs1 = inst[19:15], rs2 = inst[24:20].
- Hazard need per operand, evaluated only when the FSM is in IDLE. rs == x0 never creates a hazard.
  - ID/EX load with rd == rs: need 2.
  - ID/EX non-load write with rd == rs: need 1.
  - EX/MEM load with rd == rs: need 1.
  - Otherwise: need 0.
  - Required stall count N = max over rs1 and rs2.
- FSM states: IDLE, STALL, RESOLVE_WAIT. Reset state is IDLE.
  - IDLE, branch detected, N > 0: load cnt = N, go to STALL. stall = 1 and id_ex_bubble = 1 this cycle.
  - IDLE, branch detected, N = 0: resolve this cycle and stay in IDLE.
  - STALL: stall = 1 and id_ex_bubble = 1. cnt decrements each cycle. When cnt reaches 1, the next state is RESOLVE_WAIT.
  - RESOLVE_WAIT: resolve this cycle, then go to IDLE.
- Resolve cycle:
  - fwd_x_sel = 1 if EX/MEM writes a non-load rd == rs (rs != 0).
  - Else fwd_x_sel = 2 if MEM/WB writes rd == rs (rs != 0).
  - Else fwd_x_sel = 0. EX/MEM has priority over MEM/WB.
  - pc_redirect = if_id_flush = beq_select, combinational in the same cycle.
  - branch_count increments by 1; taken_count increments by 1 if beq_select.
- Outside the resolve cycle, fwd_x_sel still follow the same rules for whatever instruction is in IF/ID.
- Net branch penalty: the N stall cycles, plus 1 flushed slot if taken.
- stall_cycles increments on every cycle with stall = 1.
- ext_stall = 1: FSM state, cnt and all counters hold. stall, id_ex_bubble, pc_redirect and if_id_flush are forced to 0. Resolution is deferred until ext_stall deasserts.
- Counters wrap modulo 2^CNT_W.
- Reset (any time, including mid-STALL) returns the FSM to IDLE with cnt = 0 and all counters = 0. All single-bit outputs are 0 and fwd sels are 0 while rst_n = 0.
- No state is kept across branches. Back-to-back branches each evaluate hazards independently in IDLE.

Decomposition:
- Shared package holds the opcode constant BRANCH_OP = 7'b1100011, the funct3 constants (BEQ/BNE/BLT/BGE/BLTU/BGEU), the FSM state encodings and the FWD_REG/FWD_EXMEM/FWD_MEMWB encodings.
- One natural sub-module: branch_fwd_sel. It is the combinational per-operand hazard-need and forward-select logic, instantiated twice (rs1, rs2).

Test Plan:
1. BEQ x1,x2 with no producers in flight, beq_select = 1 → same cycle pc_redirect = 1, if_id_flush = 1, redirect_pc = branch_target, stall = 0; branch_count = 1, taken_count = 1.
2. ADD x5 in ID/EX, then BNE x5,x6 in IF/ID → 1 stall cycle. Resolve cycle has fwd_a_sel = 1, fwd_b_sel = 0; stall_cycles = 1.
3. LW x7 in ID/EX, then BLT x7,x0 in IF/ID → 2 stall cycles with id_ex_bubble = 1. Resolve with fwd_a_sel = 2; stall_cycles = 2.
4. As scenario 3, with ext_stall = 1 for 3 cycles after the first stall cycle → FSM holds and outputs are forced 0. Remaining stall completes after release; resolve occurs with the same counts.
5. rst_n pulsed low during the STALL state → all outputs and counters 0 immediately; FSM in IDLE after release.
6. Branch using x0 as rs1 while ID/EX writes x0 → N = 0, no stall; funct3 = 2 with opcode 1100011 → no resolve and no count.

Source files
------------

// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared constants, FSM/forward encodings and decode helpers for the ID-stage
// branch hazard controller.
package branch_hazard_ctrl_pkg;

  localparam logic [6:0] BRANCH_OP = 7'b1100011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'b00,
    ST_STALL        = 2'b01,
    ST_RESOLVE_WAIT = 2'b10
  } bh_state_e;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  // funct3 values 2 and 3 under the branch opcode are not branches
  function automatic logic is_cond_branch(input logic [6:0] opcode, input logic [2:0] funct3);
    logic hit;
    hit = 1'b0;
    if (opcode == BRANCH_OP) begin
      case (funct3)
        F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU: hit = 1'b1;
        default: hit = 1'b0;
      endcase
    end else begin
      hit = 1'b0;
    end
    return hit;
  endfunction

  function automatic logic [1:0] max_need(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] m;
    if (a > b) begin
      m = a;
    end else begin
      m = b;
    end
    return m;
  endfunction

endpackage

// File: rtl/branch_hazard_ctrl_fwd_sel.sv
// Per-operand hazard-need and comparator forward-select logic; one instance per
// source register of the branch.
module branch_fwd_sel
  import branch_hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] id_ex_rd,
  input  logic       id_ex_regwrite,
  input  logic       id_ex_memread,
  input  logic [4:0] ex_mem_rd,
  input  logic       ex_mem_regwrite,
  input  logic       ex_mem_memread,
  input  logic [4:0] mem_wb_rd,
  input  logic       mem_wb_regwrite,
  output logic [1:0] need,
  output logic [1:0] fwd_sel
);

  // Stall cycles needed before this operand can be forwarded into ID
  always_comb begin
    need = 2'd0;
    if (rs == 5'd0) begin
      need = 2'd0;
    end else if (id_ex_memread && (id_ex_rd == rs)) begin
      need = 2'd2;
    end else if (id_ex_regwrite && (id_ex_rd == rs)) begin
      need = 2'd1;
    end else if (ex_mem_memread && (ex_mem_rd == rs)) begin
      need = 2'd1;
    end else begin
      need = 2'd0;
    end
  end

  // Operand source; a load in EX/MEM has no ALU result, so it is not a source
  always_comb begin
    fwd_sel = FWD_REG;
    if (rs == 5'd0) begin
      fwd_sel = FWD_REG;
    end else if (ex_mem_regwrite && !ex_mem_memread && (ex_mem_rd == rs)) begin
      fwd_sel = FWD_EXMEM;
    end else if (mem_wb_regwrite && (mem_wb_rd == rs)) begin
      fwd_sel = FWD_MEMWB;
    end else begin
      fwd_sel = FWD_REG;
    end
  end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch sequencer: stalls for operand hazards, picks comparator
// forwarding sources, redirects/flushes on taken branches and keeps statistics.
module branch_hazard_ctrl
  import branch_hazard_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      if_id_inst_code,
  input  logic             ext_stall,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_regwrite,
  input  logic             id_ex_memread,
  input  logic [4:0]       ex_mem_rd,
  input  logic             ex_mem_regwrite,
  input  logic             ex_mem_memread,
  input  logic [4:0]       mem_wb_rd,
  input  logic             mem_wb_regwrite,
  input  logic             beq_select,
  input  logic [XLEN-1:0]  branch_target,
  output logic             stall,
  output logic             id_ex_bubble,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             pc_redirect,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             if_id_flush,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] taken_count,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [4:0] rs1_s;
  logic [4:0] rs2_s;
  logic       is_branch_s;
  logic       unused_inst_bits;
  logic [1:0] need_a_s;
  logic [1:0] need_b_s;
  logic [1:0] need_max_s;
  logic [1:0] fwd_a_s;
  logic [1:0] fwd_b_s;

  bh_state_e  state_r;
  bh_state_e  state_nxt;
  logic [1:0] cnt_r;
  logic [1:0] cnt_nxt;
  logic       stall_s;
  logic       resolve_s;

  assign rs1_s            = if_id_inst_code[19:15];
  assign rs2_s            = if_id_inst_code[24:20];
  assign is_branch_s      = is_cond_branch(if_id_inst_code[6:0], if_id_inst_code[14:12]);
  assign unused_inst_bits = ^{if_id_inst_code[31:25], if_id_inst_code[11:7]};
  assign need_max_s       = max_need(need_a_s, need_b_s);

  branch_fwd_sel u_fwd_a (
    .rs              (rs1_s),
    .id_ex_rd        (id_ex_rd),
    .id_ex_regwrite  (id_ex_regwrite),
    .id_ex_memread   (id_ex_memread),
    .ex_mem_rd       (ex_mem_rd),
    .ex_mem_regwrite (ex_mem_regwrite),
    .ex_mem_memread  (ex_mem_memread),
    .mem_wb_rd       (mem_wb_rd),
    .mem_wb_regwrite (mem_wb_regwrite),
    .need            (need_a_s),
    .fwd_sel         (fwd_a_s)
  );

  branch_fwd_sel u_fwd_b (
    .rs              (rs2_s),
    .id_ex_rd        (id_ex_rd),
    .id_ex_regwrite  (id_ex_regwrite),
    .id_ex_memread   (id_ex_memread),
    .ex_mem_rd       (ex_mem_rd),
    .ex_mem_regwrite (ex_mem_regwrite),
    .ex_mem_memread  (ex_mem_memread),
    .mem_wb_rd       (mem_wb_rd),
    .mem_wb_regwrite (mem_wb_regwrite),
    .need            (need_b_s),
    .fwd_sel         (fwd_b_s)
  );

  // FSM state and stall counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 2'd0;
    end else begin
      state_r <= state_nxt;
      cnt_r   <= cnt_nxt;
    end
  end

  // The detect cycle in IDLE is the first of the N stall cycles, so N = 1
  // goes straight to RESOLVE_WAIT once cnt is loaded with 1.
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    stall_s   = 1'b0;
    resolve_s = 1'b0;
    if (ext_stall) begin
      state_nxt = state_r;
      cnt_nxt   = cnt_r;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (is_branch_s && (need_max_s != 2'd0)) begin
            stall_s   = 1'b1;
            cnt_nxt   = need_max_s;
            state_nxt = (need_max_s == 2'd1) ? ST_RESOLVE_WAIT : ST_STALL;
          end else if (is_branch_s) begin
            resolve_s = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_STALL: begin
          stall_s = 1'b1;
          cnt_nxt = cnt_r - 2'd1;
          if (cnt_r <= 2'd2) begin
            state_nxt = ST_RESOLVE_WAIT;
          end else begin
            state_nxt = ST_STALL;
          end
        end
        ST_RESOLVE_WAIT: begin
          resolve_s = 1'b1;
          cnt_nxt   = 2'd0;
          state_nxt = ST_IDLE;
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = 2'd0;
        end
      endcase
    end
  end

  // Statistics counters, frozen with the rest of the pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count <= CNT_ZERO;
      taken_count  <= CNT_ZERO;
      stall_cycles <= CNT_ZERO;
    end else if (!ext_stall) begin
      if (stall_s) begin
        stall_cycles <= stall_cycles + CNT_ONE;
      end
      if (resolve_s) begin
        branch_count <= branch_count + CNT_ONE;
      end
      if (resolve_s && beq_select) begin
        taken_count <= taken_count + CNT_ONE;
      end
    end
  end

  // Redirect and flush must act in the resolve cycle itself, so these stay
  // combinational; rst_n gating keeps them quiet while reset is held.
  assign stall        = rst_n & stall_s;
  assign id_ex_bubble = rst_n & stall_s;
  assign pc_redirect  = rst_n & resolve_s & beq_select;
  assign if_id_flush  = rst_n & resolve_s & beq_select;
  assign fwd_a_sel    = rst_n ? fwd_a_s : FWD_REG;
  assign fwd_b_sel    = rst_n ? fwd_b_s : FWD_REG;
  assign redirect_pc  = branch_target;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Self-checking bench for branch_hazard_ctrl: directed scenarios plus a
// randomized run against a stall-budget reference model.
module tb_branch_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_id_inst_code;
  logic        ext_stall;
  logic [4:0]  id_ex_rd, ex_mem_rd, mem_wb_rd;
  logic        id_ex_regwrite, id_ex_memread;
  logic        ex_mem_regwrite, ex_mem_memread;
  logic        mem_wb_regwrite;
  logic        beq_select;
  logic [31:0] branch_target;
  logic        stall, id_ex_bubble, pc_redirect, if_id_flush;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count, taken_count, stall_cycles;

  int n_cmp  = 0;
  int n_fail = 0;

  branch_hazard_ctrl #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .if_id_inst_code(if_id_inst_code), .ext_stall(ext_stall),
    .id_ex_rd(id_ex_rd), .id_ex_regwrite(id_ex_regwrite), .id_ex_memread(id_ex_memread),
    .ex_mem_rd(ex_mem_rd), .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_memread(ex_mem_memread),
    .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite), .beq_select(beq_select),
    .branch_target(branch_target), .stall(stall), .id_ex_bubble(id_ex_bubble),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .pc_redirect(pc_redirect),
    .redirect_pc(redirect_pc), .if_id_flush(if_id_flush), .branch_count(branch_count),
    .taken_count(taken_count), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_br(input logic [2:0] f3, input logic [4:0] a, input logic [4:0] b);
    return {7'd0, b, a, f3, 5'd0, 7'b1100011};
  endfunction

  function automatic int need_of(input int rs);
    if (rs == 0) return 0;
    if (id_ex_memread && id_ex_rd == 5'(rs)) return 2;
    if (id_ex_regwrite && id_ex_rd == 5'(rs)) return 1;
    if (ex_mem_memread && ex_mem_rd == 5'(rs)) return 1;
    return 0;
  endfunction

  function automatic int fwd_of(input int rs);
    if (rs != 0 && ex_mem_regwrite && !ex_mem_memread && ex_mem_rd == 5'(rs)) return 1;
    if (rs != 0 && mem_wb_regwrite && mem_wb_rd == 5'(rs)) return 2;
    return 0;
  endfunction

  task automatic clear_inputs();
    if_id_inst_code = 32'h0000_0013;
    ext_stall = 1'b0;
    id_ex_rd = 5'd0; id_ex_regwrite = 1'b0; id_ex_memread = 1'b0;
    ex_mem_rd = 5'd0; ex_mem_regwrite = 1'b0; ex_mem_memread = 1'b0;
    mem_wb_rd = 5'd0; mem_wb_regwrite = 1'b0;
    beq_select = 1'b0; branch_target = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    if_id_inst_code = mk_br(3'd0, 5'd1, 5'd2);
    beq_select = 1'b1;
    mem_wb_rd = 5'd1; mem_wb_regwrite = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %0b want 0", stall); end
    n_cmp++; if (pc_redirect !== 1'b0) begin n_fail++; $display("FAIL rst_redirect: got %0b want 0", pc_redirect); end
    n_cmp++; if (fwd_a_sel !== 2'd0) begin n_fail++; $display("FAIL rst_fwd_a: got %0d want 0", fwd_a_sel); end
    tick();
    n_cmp++; if (branch_count !== 32'd0 || stall_cycles !== 32'd0) begin
      n_fail++; $display("FAIL rst_counters: got %0d/%0d want 0/0", branch_count, stall_cycles); end
    rst_n = 1'b1;
  endtask

  task automatic test_taken_no_hazard();
    do_reset();
    if_id_inst_code = mk_br(3'd0, 5'd1, 5'd2);
    beq_select = 1'b1;
    branch_target = 32'h0000_1234;
    #1;
    n_cmp++; if (pc_redirect !== 1'b1 || if_id_flush !== 1'b1) begin
      n_fail++; $display("FAIL s1_redirect: got %0b%0b want 11", pc_redirect, if_id_flush); end
    n_cmp++; if (redirect_pc !== 32'h0000_1234) begin n_fail++; $display("FAIL s1_pc: got %h want 00001234", redirect_pc); end
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL s1_stall: got %0b want 0", stall); end
    tick();
    clear_inputs();
    #1;
    n_cmp++; if (branch_count !== 32'd1 || taken_count !== 32'd1) begin
      n_fail++; $display("FAIL s1_counts: got %0d/%0d want 1/1", branch_count, taken_count); end
  endtask

  task automatic test_alu_hazard();
    do_reset();
    if_id_inst_code = mk_br(3'd1, 5'd5, 5'd6);
    id_ex_rd = 5'd5; id_ex_regwrite = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b1 || id_ex_bubble !== 1'b1) begin
      n_fail++; $display("FAIL s2_stall: got %0b%0b want 11", stall, id_ex_bubble); end
    tick();
    id_ex_rd = 5'd0; id_ex_regwrite = 1'b0;
    ex_mem_rd = 5'd5; ex_mem_regwrite = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL s2_resolve_stall: got %0b want 0", stall); end
    n_cmp++; if (fwd_a_sel !== 2'd1 || fwd_b_sel !== 2'd0) begin
      n_fail++; $display("FAIL s2_fwd: got %0d/%0d want 1/0", fwd_a_sel, fwd_b_sel); end
    tick();
    clear_inputs();
    #1;
    n_cmp++; if (stall_cycles !== 32'd1 || branch_count !== 32'd1 || taken_count !== 32'd0) begin
      n_fail++; $display("FAIL s2_counts: got %0d/%0d/%0d want 1/1/0", stall_cycles, branch_count, taken_count); end
  endtask

  task automatic test_load_hazard(input bit with_freeze);
    do_reset();
    if_id_inst_code = mk_br(3'd4, 5'd7, 5'd0);
    id_ex_rd = 5'd7; id_ex_regwrite = 1'b1; id_ex_memread = 1'b1;
    beq_select = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b1 || id_ex_bubble !== 1'b1) begin
      n_fail++; $display("FAIL ld_stall1: got %0b%0b want 11", stall, id_ex_bubble); end
    tick();
    id_ex_rd = 5'd0; id_ex_regwrite = 1'b0; id_ex_memread = 1'b0;
    ex_mem_rd = 5'd7; ex_mem_regwrite = 1'b1; ex_mem_memread = 1'b1;
    if (with_freeze) begin
      ext_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
        #1;
        n_cmp++; if (stall !== 1'b0 || id_ex_bubble !== 1'b0) begin
          n_fail++; $display("FAIL frz_forced: got %0b%0b want 00", stall, id_ex_bubble); end
        tick();
      end
      n_cmp++; if (stall_cycles !== 32'd1) begin n_fail++; $display("FAIL frz_hold: got %0d want 1", stall_cycles); end
      ext_stall = 1'b0;
    end
    #1;
    n_cmp++; if (stall !== 1'b1 || id_ex_bubble !== 1'b1) begin
      n_fail++; $display("FAIL ld_stall2: got %0b%0b want 11", stall, id_ex_bubble); end
    tick();
    ex_mem_rd = 5'd0; ex_mem_regwrite = 1'b0; ex_mem_memread = 1'b0;
    mem_wb_rd = 5'd7; mem_wb_regwrite = 1'b1;
    if (with_freeze) begin
      ext_stall = 1'b1;
      #1;
      n_cmp++; if (pc_redirect !== 1'b0 || fwd_a_sel !== 2'd2) begin
        n_fail++; $display("FAIL frz_defer: got redirect %0b fwd %0d want 0/2", pc_redirect, fwd_a_sel); end
      tick();
      ext_stall = 1'b0;
    end
    #1;
    n_cmp++; if (stall !== 1'b0 || fwd_a_sel !== 2'd2) begin
      n_fail++; $display("FAIL ld_resolve: got stall %0b fwd %0d want 0/2", stall, fwd_a_sel); end
    n_cmp++; if (pc_redirect !== 1'b1 || if_id_flush !== 1'b1) begin
      n_fail++; $display("FAIL ld_redirect: got %0b%0b want 11", pc_redirect, if_id_flush); end
    tick();
    clear_inputs();
    #1;
    n_cmp++; if (stall_cycles !== 32'd2 || branch_count !== 32'd1 || taken_count !== 32'd1) begin
      n_fail++; $display("FAIL ld_counts: got %0d/%0d/%0d want 2/1/1", stall_cycles, branch_count, taken_count); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    if_id_inst_code = mk_br(3'd4, 5'd7, 5'd0);
    id_ex_rd = 5'd7; id_ex_regwrite = 1'b1; id_ex_memread = 1'b1;
    tick();
    rst_n = 1'b0;
    mem_wb_rd = 5'd7; mem_wb_regwrite = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b0 || id_ex_bubble !== 1'b0 || fwd_a_sel !== 2'd0) begin
      n_fail++; $display("FAIL mid_rst_out: got %0b%0b fwd %0d want 00/0", stall, id_ex_bubble, fwd_a_sel); end
    n_cmp++; if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL mid_rst_cnt: got %0d want 0", stall_cycles); end
    tick();
    rst_n = 1'b1;
    clear_inputs();
    if_id_inst_code = mk_br(3'd0, 5'd1, 5'd2);
    beq_select = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b0 || pc_redirect !== 1'b1) begin
      n_fail++; $display("FAIL mid_rst_idle: got stall %0b redirect %0b want 0/1", stall, pc_redirect); end
    tick();
    clear_inputs();
  endtask

  task automatic test_x0_and_nonbranch();
    do_reset();
    if_id_inst_code = mk_br(3'd0, 5'd0, 5'd3);
    id_ex_rd = 5'd0; id_ex_regwrite = 1'b1;
    beq_select = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b0 || pc_redirect !== 1'b1) begin
      n_fail++; $display("FAIL x0_nostall: got stall %0b redirect %0b want 0/1", stall, pc_redirect); end
    tick();
    if_id_inst_code = mk_br(3'd2, 5'd1, 5'd2);
    id_ex_rd = 5'd1;
    #1;
    n_cmp++; if (stall !== 1'b0 || pc_redirect !== 1'b0) begin
      n_fail++; $display("FAIL f3_2_ignored: got stall %0b redirect %0b want 0/0", stall, pc_redirect); end
    tick();
    clear_inputs();
    #1;
    n_cmp++; if (branch_count !== 32'd1) begin n_fail++; $display("FAIL x0_count: got %0d want 1", branch_count); end
  endtask

  task automatic test_back_to_back_random();
    bit busy = 1'b0;
    int rem = 0;
    logic [31:0] m_br = 32'd0, m_tk = 32'd0, m_st = 32'd0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      bit is_br, e_stall, e_res;
      int n, na, nb;
      ext_stall = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) != 0)
        if_id_inst_code = mk_br(3'($urandom_range(0, 7)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      else
        if_id_inst_code = $urandom;
      id_ex_rd = 5'($urandom_range(0, 3)); id_ex_memread = ($urandom_range(0, 2) == 0);
      id_ex_regwrite = id_ex_memread | 1'($urandom_range(0, 1));
      ex_mem_rd = 5'($urandom_range(0, 3)); ex_mem_memread = ($urandom_range(0, 2) == 0);
      ex_mem_regwrite = ex_mem_memread | 1'($urandom_range(0, 1));
      mem_wb_rd = 5'($urandom_range(0, 3)); mem_wb_regwrite = 1'($urandom_range(0, 1));
      beq_select = 1'($urandom_range(0, 1));
      branch_target = $urandom;
      #1;
      is_br = (if_id_inst_code[6:0] == 7'b1100011) && (if_id_inst_code[14:12] != 3'd2) && (if_id_inst_code[14:12] != 3'd3);
      na = need_of(int'(if_id_inst_code[19:15]));
      nb = need_of(int'(if_id_inst_code[24:20]));
      n = (na > nb) ? na : nb;
      e_stall = 1'b0; e_res = 1'b0;
      if (!ext_stall) begin
        if (!busy) begin
          if (is_br && n > 0) e_stall = 1'b1;
          else if (is_br) e_res = 1'b1;
        end else if (rem > 0) e_stall = 1'b1;
        else e_res = 1'b1;
      end
      n_cmp++; if (stall !== e_stall || id_ex_bubble !== e_stall) begin
        n_fail++; $display("FAIL rnd_stall c%0d: got %0b%0b want %0b", c, stall, id_ex_bubble, e_stall); end
      n_cmp++; if (pc_redirect !== (e_res & beq_select) || if_id_flush !== (e_res & beq_select)) begin
        n_fail++; $display("FAIL rnd_redirect c%0d: got %0b%0b want %0b", c, pc_redirect, if_id_flush, e_res & beq_select); end
      n_cmp++; if (fwd_a_sel !== 2'(fwd_of(int'(if_id_inst_code[19:15]))) || fwd_b_sel !== 2'(fwd_of(int'(if_id_inst_code[24:20])))) begin
        n_fail++; $display("FAIL rnd_fwd c%0d: got %0d/%0d want %0d/%0d", c, fwd_a_sel, fwd_b_sel,
                           fwd_of(int'(if_id_inst_code[19:15])), fwd_of(int'(if_id_inst_code[24:20]))); end
      n_cmp++; if (redirect_pc !== branch_target) begin
        n_fail++; $display("FAIL rnd_pc c%0d: got %h want %h", c, redirect_pc, branch_target); end
      n_cmp++; if (branch_count !== m_br || taken_count !== m_tk || stall_cycles !== m_st) begin
        n_fail++; $display("FAIL rnd_counts c%0d: got %0d/%0d/%0d want %0d/%0d/%0d", c,
                           branch_count, taken_count, stall_cycles, m_br, m_tk, m_st); end
      tick();
      if (!ext_stall) begin
        if (!busy && is_br && n > 0) begin busy = 1'b1; rem = n - 1; end
        else if (busy && rem > 0) rem = rem - 1;
        else if (busy) busy = 1'b0;
        if (e_stall) m_st = m_st + 32'd1;
        if (e_res) m_br = m_br + 32'd1;
        if (e_res && beq_select) m_tk = m_tk + 32'd1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_taken_no_hazard();
    test_alu_hazard();
    test_load_hazard(1'b0);
    test_load_hazard(1'b1);
    test_reset_mid_stall();
    test_x0_and_nonbranch();
    test_back_to_back_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
